// File: rtl/hilo_div_e.sv
// Execute-stage signed divider with HI/LO register pair.
// Iterative 32-step restoring division on operand magnitudes; stalls the pipeline while busy.
module hilo_div_e (
    input  logic        clk,
    input  logic        rst,
    input  logic        divE,
    input  logic [1:0]  mfE,
    input  logic [31:0] data1E,
    input  logic [31:0] data2E,
    output logic        StallDivE,
    output logic [31:0] mfResultE,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  count;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic        sign_rem;
    logic        sign_quo;
    logic        div_zero;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] rem_shift;
    logic [32:0] rem_diff;
    logic        rem_ge;

    assign abs1 = data1E[31] ? (~data1E + 32'd1) : data1E;
    assign abs2 = data2E[31] ? (~data2E + 32'd1) : data2E;

    // The dividend register doubles as the quotient register: each RUN step shifts
    // a dividend bit out of the top and a quotient bit into the bottom.
    assign rem_shift = {rem[30:0], dvd[31]};
    assign rem_diff  = {1'b0, rem_shift} - {1'b0, dvs};
    assign rem_ge    = ~rem_diff[32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        StallDivE  = 1'b0;
        case (state)
            IDLE: begin
                StallDivE = divE;
                if (divE) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                StallDivE = 1'b1;
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                StallDivE  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 5'd0;
            dvd      <= 32'd0;
            dvs      <= 32'd0;
            rem      <= 32'd0;
            sign_rem <= 1'b0;
            sign_quo <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (divE) begin
                        dvd      <= abs1;
                        dvs      <= abs2;
                        rem      <= 32'd0;
                        count    <= 5'd0;
                        sign_rem <= data1E[31];
                        sign_quo <= data1E[31] ^ data2E[31];
                        div_zero <= (data2E == 32'd0);
                    end
                end
                RUN: begin
                    rem   <= rem_ge ? rem_diff[31:0] : rem_shift;
                    dvd   <= {dvd[30:0], rem_ge};
                    count <= count + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Divide by zero leaves |dividend| in the remainder, so HI comes out right on its
    // own; only LO needs forcing because the quotient sign would otherwise flip it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == FIX) begin
            lo <= div_zero ? 32'hFFFF_FFFF : (sign_quo ? (~dvd + 32'd1) : dvd);
            hi <= sign_rem ? (~rem + 32'd1) : rem;
        end
    end

    always_comb begin
        mfResultE = 32'd0;
        case (mfE)
            2'b01:   mfResultE = hi;
            2'b10:   mfResultE = lo;
            default: mfResultE = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_hilo_div_e.sv
// Self-checking bench for hilo_div_e: directed MIPS div cases plus randomized
// operands compared against a plain-arithmetic signed division model.
module tb_hilo_div_e;

    logic        clk;
    logic        rst;
    logic        divE;
    logic [1:0]  mfE;
    logic [31:0] data1E;
    logic [31:0] data2E;
    logic        StallDivE;
    logic [31:0] mfResultE;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    hilo_div_e dut (
        .clk       (clk),
        .rst       (rst),
        .divE      (divE),
        .mfE       (mfE),
        .data1E    (data1E),
        .data2E    (data2E),
        .StallDivE (StallDivE),
        .mfResultE (mfResultE),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // MIPS div semantics: truncating quotient, remainder takes the dividend's sign.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        sa = a;
        sb = b;
        if (sb == 0) begin
            q = -1;
            r = sa;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = sa;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    function automatic logic [31:0] refMf(input logic [1:0] sel, input logic [31:0] h, input logic [31:0] l);
        if (sel == 2'b01) return h;
        if (sel == 2'b10) return l;
        return 32'd0;
    endfunction

    // Presents one div in E (entered right after a posedge) and holds it like the
    // stalled pipeline would, returning one edge after DONE with divE dropped.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel, input string tag);
        logic [63:0] exp;
        int          cycles;
        exp    = refDiv(a, b);
        data1E = a;
        data2E = b;
        mfE    = sel;
        divE   = 1'b1;
        #1;
        cycles = 0;
        while (StallDivE && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "-stall"}, 32'(cycles), 32'd34);
        checkOutput({tag, "-lo"}, lo, exp[31:0]);
        checkOutput({tag, "-hi"}, hi, exp[63:32]);
        checkOutput({tag, "-mf"}, mfResultE, refMf(sel, exp[63:32], exp[31:0]));
        @(posedge clk);
        #1;
        divE = 1'b0;
        mfE  = 2'b00;
    endtask

    initial begin
        int          t0;
        logic [31:0] ra;
        logic [31:0] rb;
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        divE   = 1'b0;
        mfE    = 2'b00;
        data1E = 32'd0;
        data2E = 32'd0;

        #2;
        checkOutput("reset-stall", 32'(StallDivE), 32'd0);
        checkOutput("reset-hi", hi, 32'd0);
        checkOutput("reset-lo", lo, 32'd0);
        divE = 1'b1;
        #1;
        checkOutput("reset-stall-div", 32'(StallDivE), 32'd1);
        divE = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(32'd100, 32'd7, 2'b00, "basic");
        mfE = 2'b01;
        #1;
        checkOutput("mfhi", mfResultE, 32'd2);
        mfE = 2'b10;
        #1;
        checkOutput("mflo", mfResultE, 32'd14);
        mfE = 2'b00;
        #1;
        checkOutput("mfnone", mfResultE, 32'd0);
        mfE = 2'b11;
        #1;
        checkOutput("mf11", mfResultE, 32'd0);
        mfE = 2'b00;

        applyStimulus(-32'sd100, 32'd7, 2'b10, "neg-pos");
        checkOutput("neg-pos-lo-const", lo, 32'hFFFF_FFF2);
        checkOutput("neg-pos-hi-const", hi, 32'hFFFF_FFFE);
        applyStimulus(32'd100, -32'sd7, 2'b01, "pos-neg");
        applyStimulus(-32'sd100, -32'sd7, 2'b01, "neg-neg");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, "overflow");
        checkOutput("overflow-lo-const", lo, 32'h8000_0000);
        applyStimulus(32'd5, 32'd0, 2'b01, "divzero");
        checkOutput("divzero-lo-const", lo, 32'hFFFF_FFFF);
        applyStimulus(-32'sd5, 32'd0, 2'b10, "divzero-neg");

        t0 = $time;
        applyStimulus(32'd100, 32'd7, 2'b00, "b2b-first");
        applyStimulus(32'd9, 32'd3, 2'b00, "b2b-second");
        checkOutput("b2b-cycles", 32'(($time - t0) / 10), 32'd70);

        // Abort a divide partway through RUN; HI/LO from before must be wiped by reset only.
        data1E = 32'd1000;
        data2E = 32'd3;
        divE   = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        checkOutput("midrun-stall", 32'(StallDivE), 32'd1);
        divE = 1'b0;
        rst  = 1'b1;
        mfE  = 2'b01;
        #1;
        checkOutput("midrun-rst-stall", 32'(StallDivE), 32'd0);
        checkOutput("midrun-rst-hi", hi, 32'd0);
        checkOutput("midrun-rst-lo", lo, 32'd0);
        checkOutput("midrun-rst-mf", mfResultE, 32'd0);
        mfE = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'd20, 32'd6, 2'b10, "after-rst");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 200)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
                2: rb = 32'd0;
                default: rb = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            applyStimulus(ra, rb, 2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
